// File: rtl/lift_pkg.sv
// Shared types and default sizing for the ping-pong lift scheduler.
package lift_pkg;

   localparam int LIFT_CW    = 30;
   localparam int LIFT_LANES = 8;
   localparam int LIFT_NQ    = 6;
   localparam int LIFT_NP    = 7;

   typedef enum logic {
      LIFT_SMALL = 1'b0,
      LIFT_BIG   = 1'b1
   } lift_mode_e;

   typedef enum logic [1:0] {
      BANK_FREE   = 2'd0,
      BANK_FILLED = 2'd1,
      BANK_BUSY   = 2'd2
   } bank_state_e;

   typedef enum logic {
      SCH_IDLE = 1'b0,
      SCH_RUN  = 1'b1
   } sched_state_e;

endpackage

// File: rtl/lift_pp_bank.sv
// One residue bank: word-wide write port, registered single-lane read with
// a range guard, and the bank's FREE/FILLED/BUSY state plus its mode bit.
module lift_pp_bank
   import lift_pkg::*;
#(
   parameter int CW    = LIFT_CW,
   parameter int LANES = LIFT_LANES,
   parameter int NQ    = LIFT_NQ,
   parameter int NP    = LIFT_NP,
   parameter int AW    = $clog2(NQ + NP),
   parameter int LW    = $clog2(LANES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [LANES*CW-1:0]   wdata,
   input  logic                  close,
   input  logic                  close_mode,
   input  logic                  start,
   input  logic                  free_bank,
   input  logic [AW-1:0]         rd_addr,
   input  logic [LW-1:0]         rd_lane,
   input  logic [AW:0]           rd_limit,
   output logic [CW-1:0]         rd_data,
   output bank_state_e           state,
   output logic                  mode
);

   logic [LANES-1:0][CW-1:0] mem [NQ+NP];

   // NOTE: storage arrays carry no reset; only control state and outputs do.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // NOTE: all sequential state uses non-blocking assignment so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_data <= '0;
      end else begin
         rd_data <= ({1'b0, rd_addr} < rd_limit) ? mem[rd_addr][rd_lane] : '0;
      end
   end

   // The scheduler only issues each control pulse from the matching state,
   // so the three transitions never collide.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= BANK_FREE;
         mode  <= LIFT_SMALL;
      end else if (close) begin
         state <= BANK_FILLED;
         mode  <= close_mode;
      end else if (start) begin
         state <= BANK_BUSY;
      end else if (free_bank) begin
         state <= BANK_FREE;
      end
   end

endmodule

// File: rtl/lift_pp_sched.sv
// Ping-pong bank front end, engine scheduler and packed result buffer for an
// external small/big lift engine.
module lift_pp_sched
   import lift_pkg::*;
#(
   parameter int CW    = LIFT_CW,
   parameter int LANES = LIFT_LANES,
   parameter int NQ    = LIFT_NQ,
   parameter int NP    = LIFT_NP,
   parameter int AW    = $clog2(NQ + NP),
   parameter int LW    = $clog2(LANES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mode,
   input  logic [AW-1:0]         ext_addr,
   input  logic [LANES*CW-1:0]   ext_din,
   input  logic                  ext_we,
   input  logic                  ext_we_done,
   output logic                  in_ready,
   output logic                  eng_start,
   output logic                  eng_mode,
   input  logic [AW-1:0]         eng_rd_addr,
   input  logic [LW-1:0]         eng_rd_lane,
   output logic [CW-1:0]         eng_rd_data,
   input  logic                  eng_res_we,
   input  logic [LW-1:0]         eng_res_lane,
   input  logic [CW-1:0]         eng_res_data,
   input  logic                  eng_done,
   output logic                  result_valid,
   input  logic                  result_read_en,
   output logic [LANES*CW-1:0]   ext_dout,
   output logic [15:0]           batch_cnt,
   output logic                  err_incomplete
);

   localparam int AWX = AW + 1;
   localparam logic [AW:0] WORDS_Q = AWX'(NQ);
   localparam logic [AW:0] WORDS_B = AWX'(NQ + NP);

   function automatic logic [AW:0] words(input logic m);
      return (m == LIFT_BIG) ? WORDS_B : WORDS_Q;
   endfunction

   logic                     wb, rb, rd_sel;
   sched_state_e             sched;
   bank_state_e              bank_state [2];
   logic                     bank_mode  [2];
   logic [CW-1:0]            bank_rd    [2];
   logic [1:0]               bank_we, bank_close, bank_start, bank_free;
   logic [LANES-1:0]         mask;
   logic [LANES-1:0][CW-1:0] res;
   logic [AW:0]              rd_limit;
   logic                     wr_ok, close_ok, launch, finish;

   assign in_ready = (bank_state[wb] == BANK_FREE);
   assign wr_ok    = ext_we && in_ready && ({1'b0, ext_addr} < words(mode));
   assign close_ok = ext_we_done && in_ready;
   assign launch   = (sched == SCH_IDLE) && (bank_state[rb] == BANK_FILLED) &&
                     !result_valid && (mask == '0);
   assign finish   = (sched == SCH_RUN) && eng_done;
   assign rd_limit = words(eng_mode);

   // NOTE: every signal driven here gets a default first, so no latch is inferred.
   always_comb begin
      bank_we    = '0;
      bank_close = '0;
      bank_start = '0;
      bank_free  = '0;
      bank_we[wb]    = wr_ok;
      bank_close[wb] = close_ok;
      bank_start[rb] = launch;
      bank_free[rb]  = finish;
   end

   for (genvar i = 0; i < 2; i++) begin : g_bank
      lift_pp_bank #(
         .CW(CW), .LANES(LANES), .NQ(NQ), .NP(NP), .AW(AW), .LW(LW)
      ) u_bank (
         .clk        (clk),
         .rst        (rst),
         .we         (bank_we[i]),
         .waddr      (ext_addr),
         .wdata      (ext_din),
         .close      (bank_close[i]),
         .close_mode (mode),
         .start      (bank_start[i]),
         .free_bank  (bank_free[i]),
         .rd_addr    (eng_rd_addr),
         .rd_lane    (eng_rd_lane),
         .rd_limit   (rd_limit),
         .rd_data    (bank_rd[i]),
         .state      (bank_state[i]),
         .mode       (bank_mode[i])
      );
   end

   assign eng_rd_data = bank_rd[rd_sel];

   always_ff @(posedge clk) begin
      if (!rst) wb <= 1'b0;
      else if (close_ok) wb <= ~wb;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sched     <= SCH_IDLE;
         rb        <= 1'b0;
         eng_start <= 1'b0;
         eng_mode  <= LIFT_SMALL;
         rd_sel    <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         rd_sel    <= rb;
         case (sched)
            SCH_IDLE: begin
               if (launch) begin
                  eng_start <= 1'b1;
                  eng_mode  <= bank_mode[rb];
                  sched     <= SCH_RUN;
               end
            end
            SCH_RUN: begin
               if (eng_done) begin
                  rb    <= ~rb;
                  sched <= SCH_IDLE;
               end
            end
            default: sched <= SCH_IDLE;
         endcase
      end
   end

   // Lane payloads live outside reset like the banks; only the mask gates them.
   always_ff @(posedge clk) begin
      if (eng_res_we) res[eng_res_lane] <= eng_res_data;
   end
   assign ext_dout = res;

   // A pop wins over everything; an incomplete done drops the partial mask so
   // the scheduler's mask==0 launch condition can be met again.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mask           <= '0;
         result_valid   <= 1'b0;
         batch_cnt      <= '0;
         err_incomplete <= 1'b0;
      end else if (result_valid && result_read_en) begin
         mask         <= '0;
         result_valid <= 1'b0;
         batch_cnt    <= batch_cnt + 16'd1;
      end else begin
         if (finish && (mask != '1)) begin
            err_incomplete <= 1'b1;
            mask           <= '0;
         end else if (eng_res_we) begin
            mask[eng_res_lane] <= 1'b1;
         end
         if ((mask == '1) && !result_valid) result_valid <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lift_pp_sched.sv
// Directed bench for lift_pp_sched: ping-pong fill, engine reads, result
// packing, incomplete batches and mid-run reset.
module tb_lift_pp_sched;

   localparam int CW    = 30;
   localparam int LANES = 8;
   localparam int NQ    = 6;
   localparam int NP    = 7;
   localparam int AW    = 4;
   localparam int LW    = 3;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  mode;
   logic [AW-1:0]         ext_addr;
   logic [LANES*CW-1:0]   ext_din;
   logic                  ext_we, ext_we_done;
   logic                  in_ready, eng_start, eng_mode;
   logic [AW-1:0]         eng_rd_addr;
   logic [LW-1:0]         eng_rd_lane;
   logic [CW-1:0]         eng_rd_data;
   logic                  eng_res_we;
   logic [LW-1:0]         eng_res_lane;
   logic [CW-1:0]         eng_res_data;
   logic                  eng_done;
   logic                  result_valid, result_read_en;
   logic [LANES*CW-1:0]   ext_dout;
   logic [15:0]           batch_cnt;
   logic                  err_incomplete;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   lift_pp_sched #(.CW(CW), .LANES(LANES), .NQ(NQ), .NP(NP), .AW(AW), .LW(LW)) dut (
      .clk(clk), .rst(rst), .mode(mode),
      .ext_addr(ext_addr), .ext_din(ext_din), .ext_we(ext_we), .ext_we_done(ext_we_done),
      .in_ready(in_ready), .eng_start(eng_start), .eng_mode(eng_mode),
      .eng_rd_addr(eng_rd_addr), .eng_rd_lane(eng_rd_lane), .eng_rd_data(eng_rd_data),
      .eng_res_we(eng_res_we), .eng_res_lane(eng_res_lane), .eng_res_data(eng_res_data),
      .eng_done(eng_done), .result_valid(result_valid), .result_read_en(result_read_en),
      .ext_dout(ext_dout), .batch_cnt(batch_cnt), .err_incomplete(err_incomplete)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [LANES*CW-1:0] pat(input int w);
      logic [LANES*CW-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*CW +: CW] = CW'(w * 8 + k);
      return v;
   endfunction

   function automatic logic [LANES*CW-1:0] fill(input int val);
      logic [LANES*CW-1:0] v;
      for (int k = 0; k < LANES; k++) v[k*CW +: CW] = CW'(val);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic write_word(input int a, input logic [LANES*CW-1:0] d, input logic m,
                             input logic last);
      ext_addr = AW'(a); ext_din = d; mode = m; ext_we = 1'b1; ext_we_done = last;
      tick();
      ext_we = 1'b0; ext_we_done = 1'b0;
   endtask

   // Words 0..n-1 with the w*8+k pattern; the close rides on the last write.
   task automatic burst(input int n, input logic m);
      for (int w = 0; w < n; w++) write_word(w, pat(w), m, w == n - 1);
   endtask

   task automatic wait_start(output int seen);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (eng_start) begin seen = 1; break; end
      end
   endtask

   task automatic count_starts(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (eng_start) n++;
      end
   endtask

   task automatic rd(input int a, input int l, output logic [CW-1:0] d);
      eng_rd_addr = AW'(a); eng_rd_lane = LW'(l);
      tick();
      d = eng_rd_data;
   endtask

   task automatic res_write(input int l, input int v);
      eng_res_we = 1'b1; eng_res_lane = LW'(l); eng_res_data = CW'(v);
      tick();
      eng_res_we = 1'b0;
   endtask

   task automatic done_pulse();
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
   endtask

   task automatic wait_valid(output int seen);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (result_valid) begin seen = 1; break; end
         tick();
      end
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, " in_ready"},     in_ready, 1);
      check({pfx, " eng_start"},    eng_start, 0);
      check({pfx, " eng_mode"},     eng_mode, 0);
      check({pfx, " eng_rd_data"},  eng_rd_data, 0);
      check({pfx, " result_valid"}, result_valid, 0);
      check({pfx, " batch_cnt"},    batch_cnt, 0);
      check({pfx, " err"},          err_incomplete, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen, n;
      logic [CW-1:0] d;

      rst = 1'b0; mode = 1'b0; ext_addr = '0; ext_din = '0; ext_we = 1'b0;
      ext_we_done = 1'b0; eng_rd_addr = '0; eng_rd_lane = '0; eng_res_we = 1'b0;
      eng_res_lane = '0; eng_res_data = '0; eng_done = 1'b0; result_read_en = 1'b0;
      tick(); tick();
      check_reset("reset");
      rst = 1'b1;
      tick();

      // Small batch in bank0; word 7 is pre-loaded in big mode so the small-mode
      // range guard has stale data to hide.
      write_word(7, fill(12345), 1'b1, 1'b0);
      write_word(6, fill(777), 1'b0, 1'b0);
      burst(NQ, 1'b0);
      wait_start(seen);
      check("small start", seen, 1);
      check("small eng_mode", eng_mode, 0);
      rd(3, 2, d);
      check("eng_start one pulse", eng_start, 0);
      check("rd (3,2)", d, 26);
      rd(7, 0, d);  check("rd (7,0) out of range", d, 0);
      rd(6, 1, d);  check("rd (6,1) out of range", d, 0);
      rd(5, 7, d);  check("rd (5,7)", d, 47);

      // Big batch into bank1 while bank0 is BUSY; last write shares the close.
      burst(NQ + NP, 1'b1);
      check("in_ready both banks taken", in_ready, 0);

      // Third burst must be dropped entirely.
      write_word(0, fill(555), 1'b0, 1'b1);
      count_starts(3, n);
      check("in_ready still 0", in_ready, 0);
      check("no start while RUN", n, 0);

      // Full result from the engine, lanes 7..0.
      for (int l = LANES - 1; l >= 0; l--) res_write(l, 100 + l);
      wait_valid(seen);
      check("result_valid", seen, 1);
      check("dout lane0", ext_dout[0 +: CW], 100);
      check("dout lane7", ext_dout[7*CW +: CW], 107);
      check("dout lane3", ext_dout[3*CW +: CW], 103);
      done_pulse();
      check("in_ready after done", in_ready, 1);
      check("no err on full mask", err_incomplete, 0);
      count_starts(5, n);
      check("start blocked until pop", n, 0);

      result_read_en = 1'b1;
      tick();
      result_read_en = 1'b0;
      check("valid after pop", result_valid, 0);
      check("batch_cnt after pop", batch_cnt, 1);
      check("dout holds after pop", ext_dout[7*CW +: CW], 107);
      wait_start(seen);
      check("big start", seen, 1);
      check("big eng_mode", eng_mode, 1);
      rd(12, 7, d); check("rd (12,7)", d, 103);
      rd(0, 5, d);  check("rd (0,5) third burst dropped", d, 5);

      // Incomplete result: only lanes 0..3 before done.
      for (int l = 0; l < 4; l++) res_write(l, 200 + l);
      done_pulse();
      tick();
      check("err_incomplete", err_incomplete, 1);
      tick(); tick();
      check("valid after incomplete", result_valid, 0);
      check("batch_cnt unchanged", batch_cnt, 1);

      burst(NQ, 1'b0);
      wait_start(seen);
      check("start after incomplete", seen, 1);
      check("eng_mode after incomplete", eng_mode, 0);
      rd(1, 1, d);  check("rd (1,1)", d, 9);

      // Reset while the engine owns a bank.
      rst = 1'b0;
      tick();
      check_reset("mid-run reset");
      rst = 1'b1;
      count_starts(4, n);
      check("no start after reset", n, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
